// File: rtl/clk_meas_pkg.sv
// ----------------------------------------------------------------------------
// clk_meas_pkg
//   Shared types and elaboration-time helpers for the clock period meter.
//   - state_e  : measurement FSM states (IDLE, ARM, MEAS)
//   - exp_cyc  : expected clk_m period expressed in clk_i cycles
//   - cw_of    : counter width able to hold 0..timeout inclusive
// ----------------------------------------------------------------------------
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_e;

    // Integer division: the divider is expected to produce a period that is
    // an exact multiple of the system clock period.
    function automatic int exp_cyc(input int period, input int clkperiod);
        return period / clkperiod;
    endfunction

    function automatic int cw_of(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// ----------------------------------------------------------------------------
// clk_period_meter_if
//   Groups the measurement inputs and result outputs of clk_period_meter.
//   Parameter CW must equal the meter's counter width.
//
//   Signals
//     en          enable for the measurement (driven by master)
//     clk_m       measured clock, asynchronous to clk_i (driven by master)
//     period_o    last reported period in clk_i cycles (driven by slave)
//     valid_o     one-cycle strobe when period_o updates
//     in_range_o  last reported period within tolerance
//     locked_o    enough consecutive in-range periods seen
//     stuck_o     clk_m produced no rising edge within the timeout
//     state_o     FSM state, debug visibility (clk_meas_pkg::state_e encoding)
//
//   Handshake: valid_o is a pure strobe with no back-pressure. It is high for
//   exactly one clk_i cycle per reported sample, period_o/in_range_o/locked_o
//   are valid in that same cycle and hold their value afterwards; a consumer
//   that is not watching during the strobe cycle misses that event only.
// ----------------------------------------------------------------------------
interface clk_period_meter_if #(
    parameter int CW = 8
);
    logic          en;
    logic          clk_m;
    logic [CW-1:0] period_o;
    logic          valid_o;
    logic          in_range_o;
    logic          locked_o;
    logic          stuck_o;
    logic [1:0]    state_o;

    modport master (
        output en,
        output clk_m,
        input  period_o,
        input  valid_o,
        input  in_range_o,
        input  locked_o,
        input  stuck_o,
        input  state_o
    );

    modport slave (
        input  en,
        input  clk_m,
        output period_o,
        output valid_o,
        output in_range_o,
        output locked_o,
        output stuck_o,
        output state_o
    );
endinterface

// File: rtl/sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
//   Brings an asynchronous level into the clk_i domain through two flops and
//   a third edge-history flop, producing a one-cycle pulse per rising edge.
//
//   Ports
//     clk_i   in   system clock
//     rst     in   asynchronous, active-high reset (all flops to 0)
//     d_i     in   asynchronous input level
//     rise_o  out  one-cycle pulse after a synchronised 0->1 transition
// ----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk_i,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    // High during the cycle after sync_q first shows the new level, so the
    // consuming logic acts on it at the third clk_i edge after clk_m rose.
    assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/clk_period_meter.sv
// ----------------------------------------------------------------------------
// clk_period_meter
//   Measures the period of a slow asynchronous clock clk_m in clk_i cycles and
//   flags it as in range, locked, or stuck against an expected period.
//   Intended to gate serial receivers until their bit clock is trustworthy.
//
//   Parameters
//     PERIOD     expected clk_m period, ns
//     CLKPERIOD  clk_i period, ns
//     TOL        allowed |measured - expected|, clk_i cycles
//     LOCK_CNT   consecutive in-range samples needed for locked_o
//
//   Ports
//     clk_i   in   system clock
//     rst     in   asynchronous, active-high reset
//     bus     slave modport of clk_period_meter_if:
//               en, clk_m in; period_o, valid_o, in_range_o, locked_o,
//               stuck_o, state_o out
//
//   Build option
//     CLKMEAS_AVG4_EN  when defined, four consecutive periods are summed and
//                      their truncated mean is reported once per four rises;
//                      range and lock decisions use the mean.
// ----------------------------------------------------------------------------
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int PERIOD    = 1020,
    parameter int CLKPERIOD = 10,
    parameter int TOL       = 2,
    parameter int LOCK_CNT  = 4
) (
    input  logic                clk_i,
    input  logic                rst,
    clk_period_meter_if.slave   bus
);

    localparam int EXP_CYC     = exp_cyc(PERIOD, CLKPERIOD);
    localparam int TIMEOUT_CYC = 2 * EXP_CYC;
    localparam int CW          = cw_of(TIMEOUT_CYC);
    localparam int LW          = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] EXP_V = CW'(EXP_CYC);
    localparam logic [CW-1:0] TMO_V = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] TOL_V = CW'(TOL);
    localparam logic [LW-1:0] LCK_V = LW'(LOCK_CNT);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ARM  = ARM;
    localparam logic [1:0] S_MEAS = MEAS;

    // ------------------------------------------------------------------
    // clk_m edge detection
    // ------------------------------------------------------------------
    logic rise;

    sync_edge_det u_sync (
        .clk_i  (clk_i),
        .rst    (rst),
        .d_i    (bus.clk_m),
        .rise_o (rise)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [CW-1:0] period_q,   period_d;
    logic          valid_q,    valid_d;
    logic          in_range_q, in_range_d;
    logic [LW-1:0] lock_q,     lock_d;
    logic          locked_q,   locked_d;
    logic          stuck_q,    stuck_d;
`ifdef CLKMEAS_AVG4_EN
    logic [CW+1:0] sum_q,      sum_d;
    logic [1:0]    phase_q,    phase_d;
    logic [CW+1:0] acc_v;
`endif

    // Combinational helpers for the sample path
    logic          take_v;
    logic [CW-1:0] sample_v;
    logic [CW-1:0] diff_v;
    logic          ok_v;
    logic          timeout;

    // A rise in the same cycle as the saturation point is still a sample.
    assign timeout = (cnt_q == TMO_V) && !rise;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        lock_d     = lock_q;
        locked_d   = locked_q;
        stuck_d    = stuck_q;
`ifdef CLKMEAS_AVG4_EN
        sum_d      = sum_q;
        phase_d    = phase_q;
        acc_v      = sum_q + {2'b00, cnt_q};
`endif
        take_v     = 1'b0;
        sample_v   = cnt_q;
        diff_v     = '0;
        ok_v       = 1'b0;

        // Interval counter: restarts at 1 on each rise so that at the next
        // rise it holds exactly the number of cycles between the two.
        if (!bus.en || state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (rise) begin
            cnt_d = CW'(1);
        end else if (cnt_q != TMO_V) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (!bus.en) begin
            state_d  = S_IDLE;
            lock_d   = '0;
            locked_d = 1'b0;
`ifdef CLKMEAS_AVG4_EN
            sum_d    = '0;
            phase_d  = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                end

                S_ARM: begin
                    // First rise only establishes a reference edge.
                    if (rise) begin
                        state_d = S_MEAS;
                        stuck_d = 1'b0;
                    end else if (timeout) begin
                        stuck_d    = 1'b1;
                        in_range_d = 1'b0;
                        lock_d     = '0;
                        locked_d   = 1'b0;
                    end
                end

                S_MEAS: begin
                    if (rise) begin
`ifdef CLKMEAS_AVG4_EN
                        if (phase_q == 2'd3) begin
                            take_v   = 1'b1;
                            sample_v = acc_v[CW+1:2];
                            sum_d    = '0;
                            phase_d  = '0;
                        end else begin
                            sum_d    = acc_v;
                            phase_d  = phase_q + 2'd1;
                        end
`else
                        take_v   = 1'b1;
                        sample_v = cnt_q;
`endif
                    end else if (timeout) begin
                        state_d    = S_ARM;
                        stuck_d    = 1'b1;
                        in_range_d = 1'b0;
                        lock_d     = '0;
                        locked_d   = 1'b0;
`ifdef CLKMEAS_AVG4_EN
                        sum_d      = '0;
                        phase_d    = '0;
`endif
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (take_v) begin
            // Unsigned distance, computed in the direction that cannot wrap.
            diff_v     = (sample_v >= EXP_V) ? (sample_v - EXP_V) : (EXP_V - sample_v);
            ok_v       = (diff_v <= TOL_V);
            period_d   = sample_v;
            valid_d    = 1'b1;
            in_range_d = ok_v;
            if (ok_v) begin
                lock_d = (lock_q == LCK_V) ? lock_q : (lock_q + LW'(1));
            end else begin
                lock_d = '0;
            end
            locked_d = (lock_d == LCK_V);
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            lock_q     <= '0;
            locked_q   <= 1'b0;
            stuck_q    <= 1'b0;
`ifdef CLKMEAS_AVG4_EN
            sum_q      <= '0;
            phase_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            lock_q     <= lock_d;
            locked_q   <= locked_d;
            stuck_q    <= stuck_d;
`ifdef CLKMEAS_AVG4_EN
            sum_q      <= sum_d;
            phase_q    <= phase_d;
`endif
        end
    end

    assign bus.period_o   = period_q;
    assign bus.valid_o    = valid_q;
    assign bus.in_range_o = in_range_q;
    assign bus.locked_o   = locked_q;
    assign bus.stuck_o    = stuck_q;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
module tb_clk_period_meter;
  import clk_meas_pkg::*;

  localparam int PERIOD      = 1020;
  localparam int CLKPERIOD   = 10;
  localparam int TOL         = 2;
  localparam int LOCK_CNT    = 4;
  localparam int EXP_CYC     = PERIOD / CLKPERIOD;
  localparam int TIMEOUT_CYC = 2 * EXP_CYC;
  localparam int CW          = $clog2(TIMEOUT_CYC + 1);
  localparam int W           = CW + 2;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst   = 1'b1;

  initial forever #5 clk_i = ~clk_i;

  clk_period_meter_if #(.CW(CW)) bus ();

  clk_period_meter #(
    .PERIOD    (PERIOD),
    .CLKPERIOD (CLKPERIOD),
    .TOL       (TOL),
    .LOCK_CNT  (LOCK_CNT)
  ) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $realtime);
    end
  endtask

  // ---------------- clk_m generator ----------------
  // Rising edges sit 3 ns past a 10 ns grid, never on a clk_i edge.
  int      per_ns    = PERIOD;
  int      per_q[$];
  bit      hold_low  = 1'b0;
  realtime last_rise_t = 0.0;

  initial begin
    int cur;
    bus.clk_m = 1'b0;
    #103;
    forever begin
      if (hold_low) begin
        bus.clk_m = 1'b0;
        #10;
      end else begin
        cur = (per_q.size() > 0) ? per_q.pop_front() : per_ns;
        bus.clk_m   = 1'b1;
        last_rise_t = $realtime;
        #(cur / 2);
        bus.clk_m = 1'b0;
        #(cur - cur / 2);
      end
    end
  end

  // ---------------- reference model ----------------
  // Works on rise-to-rise intervals: every interval no longer than the
  // timeout is a sample, a longer one means the meter gave up and the rise
  // that ends it becomes a fresh reference.
  logic [W-1:0] exp_q[$];
  bit      have_ref = 1'b0;
  realtime ref_t    = 0.0;
  int      lock_m   = 0;
  bit      locked_m = 1'b0;
  int      sum_m    = 0;
  int      phase_m  = 0;

  task automatic model_reset();
    have_ref = 1'b0;
    lock_m   = 0;
    locked_m = 1'b0;
    sum_m    = 0;
    phase_m  = 0;
  endtask

  task automatic model_emit(input int v);
    bit inr;
    inr = (v >= EXP_CYC - TOL) && (v <= EXP_CYC + TOL);
    if (inr) lock_m = (lock_m < LOCK_CNT) ? lock_m + 1 : LOCK_CNT;
    else     lock_m = 0;
    locked_m = (lock_m == LOCK_CNT);
    exp_q.push_back({CW'(v), inr, locked_m});
  endtask

  always @(posedge bus.clk_m) begin
    int iv;
    if (!rst && bus.en) begin
      if (!have_ref) begin
        have_ref = 1'b1;
        ref_t    = $realtime;
      end else begin
        iv    = int'(($realtime - ref_t) / CLKPERIOD);
        ref_t = $realtime;
        if (iv > TIMEOUT_CYC) begin
          lock_m   = 0;
          locked_m = 1'b0;
          sum_m    = 0;
          phase_m  = 0;
        end else begin
`ifdef CLKMEAS_AVG4_EN
          sum_m   += iv;
          phase_m += 1;
          if (phase_m == 4) begin
            model_emit(sum_m / 4);
            sum_m   = 0;
            phase_m = 0;
          end
`else
          model_emit(iv);
`endif
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    logic [W-1:0] e;
    if (!rst && bus.valid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: period_o=%0d with no expected sample (t=%0t)",
                 bus.period_o, $realtime);
      end else begin
        e = exp_q.pop_front();
        check("period_o",   int'(bus.period_o),   int'(e[W-1:2]));
        check("in_range_o", int'(bus.in_range_o), int'(e[1]));
        check("locked_o",   int'(bus.locked_o),   int'(e[0]));
        check("stuck_on_valid", int'(bus.stuck_o), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a clk_m rise; the n intervals of p ns start at the
  // next rise, and the task returns just after the rise that ends the last.
  task automatic run_periods(input int p, input int n);
    repeat (n) per_q.push_back(p);
    while (per_q.size() != 0) @(posedge bus.clk_m);
    @(posedge bus.clk_m);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"},   int'(bus.period_o),   0);
    check({tag, "_valid"},    int'(bus.valid_o),    0);
    check({tag, "_in_range"}, int'(bus.in_range_o), 0);
    check({tag, "_locked"},   int'(bus.locked_o),   0);
    check({tag, "_stuck"},    int'(bus.stuck_o),    0);
  endtask

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600_000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit, %0d samples pending", exp_q.size());
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.en = 1'b0;
    #22;
    check_all_zero("reset");
    check("reset_state", int'(bus.state_o), int'(IDLE));
    #30;
    rst    = 1'b0;
    bus.en = 1'b1;
    model_reset();
    @(posedge bus.clk_m);
    #1;

    // nominal clock, lock acquisition
    run_periods(1020, 8);

    // off-frequency sample breaks lock, then relock
    run_periods(1100, 1);
    run_periods(1020, 6);

    // tolerance boundaries
    run_periods(1000, 1);
    run_periods(1040, 1);
    run_periods(990, 1);
    run_periods(1050, 1);
    run_periods(1020, 5);

    // exactly the timeout is a sample, one cycle more is a timeout
    run_periods(2040, 1);
    run_periods(1020, 5);
    run_periods(2050, 1);
    run_periods(1020, 5);

    // randomized periods around nominal
    repeat (24) run_periods(int'($urandom_range(96, 108)) * 10, 1);
    run_periods(1020, 5);

    // clk_m stuck low
    hold_low = 1'b1;
    #(last_rise_t + 2030.0 - $realtime);
    check("stuck_early", int'(bus.stuck_o), 0);
    #80;
    check("stuck_set", int'(bus.stuck_o), 1);
    check("stuck_locked", int'(bus.locked_o), 0);
    check("stuck_in_range", int'(bus.in_range_o), 0);
    hold_low = 1'b0;
    @(posedge bus.clk_m);
    #1;
    run_periods(1020, 6);

    // enable dropped mid-period, rises ignored while low
    #400;
    bus.en = 1'b0;
    model_reset();
    @(posedge bus.clk_m);
    #1;
    check("en_low_state", int'(bus.state_o), int'(IDLE));
    check("en_low_locked", int'(bus.locked_o), 0);
    @(posedge bus.clk_m);
    #400;
    bus.en = 1'b1;
    @(posedge bus.clk_m);
    #1;
    run_periods(1020, 6);

    // asynchronous reset mid-period, released while clk_m is low
    #602;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("midrst");
    #40;
    rst = 1'b0;
    @(posedge bus.clk_m);
    #1;
    run_periods(1020, 6);

`ifdef CLKMEAS_AVG4_EN
    // averaging window aligned to a fresh arm: 1000/1020/1040/1020
    #400;
    bus.en = 1'b0;
    model_reset();
    @(posedge bus.clk_m);
    #400;
    bus.en = 1'b1;
    per_q.push_back(1000);
    per_q.push_back(1020);
    per_q.push_back(1040);
    per_q.push_back(1020);
    while (per_q.size() != 0) @(posedge bus.clk_m);
    @(posedge bus.clk_m);
    #1;
    run_periods(1020, 4);
`endif

    repeat (20) @(negedge clk_i);
    check("pending_samples", exp_q.size(), 0);
    summary();
    $finish;
  end

endmodule
